// File: rtl/ras_retire_update.sv
// rtl/ras_retire_update.sv - commit-side RAS call/return update producer
//
// Purpose: classify up to two retired control transfers per cycle as call or
// return, buffer them in a small FIFO, and issue one committed-RAS update per
// cycle. A commit-time redirect drains the FIFO, then pulses UpdateReload.
//
// Ports:
//   Clk, Rest                       clock, async active-high reset
//   Retire{0,1}Able/Pc/Type         retire slots (slot 0 older)
//   RetireRedirect                  commit-time redirect
//   RetireStall                     combinational; ROB must hold its slots
//   UpdateInAble/Call/Return/InDate registered committed-RAS update
//   UpdateReload                    registered one-cycle reload pulse
module ras_retire_update #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              Retire0Able,
    input  logic [ADDR_W-1:0] Retire0Pc,
    input  logic [1:0]        Retire0Type,
    input  logic              Retire1Able,
    input  logic [ADDR_W-1:0] Retire1Pc,
    input  logic [1:0]        Retire1Type,
    input  logic              RetireRedirect,
    output logic              RetireStall,
    output logic              UpdateInAble,
    output logic              UpdateCall,
    output logic              UpdateReturn,
    output logic [ADDR_W-1:0] UpdateInDate,
    output logic              UpdateReload
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, RELOAD} state_t;

    // Entry layout: {is_call, return_address}; returns store a zero address.
    logic [ADDR_W:0] mem_q [FIFO_DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   free_cnt;
    logic            push0, push1, pop;
    logic [ADDR_W:0] entry0, entry1, head;
    logic [AW-1:0]   wr_ptr1;
    logic            reload_d;

    assign free_cnt    = CW'(FIFO_DEPTH) - count_q;
    assign RetireStall = (state_q != RUN) || (free_cnt < CW'(2));

    assign push0 = !RetireStall && Retire0Able &&
                   (Retire0Type == 2'b01 || Retire0Type == 2'b10);
    assign push1 = !RetireStall && Retire1Able &&
                   (Retire1Type == 2'b01 || Retire1Type == 2'b10);
    assign pop   = (count_q != '0);

    assign entry0 = (Retire0Type == 2'b01) ? {1'b1, Retire0Pc + ADDR_W'(4)}
                                           : {1'b0, {ADDR_W{1'b0}}};
    assign entry1 = (Retire1Type == 2'b01) ? {1'b1, Retire1Pc + ADDR_W'(4)}
                                           : {1'b0, {ADDR_W{1'b0}}};

    // Slot 1 goes right after slot 0 when both push, otherwise into the tail.
    assign wr_ptr1 = wr_ptr_q + AW'(push0);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge Clk) begin
        if (push0) mem_q[wr_ptr_q] <= entry0;
        if (push1) mem_q[wr_ptr1]  <= entry1;
    end

    always_comb begin
        state_d  = state_q;
        reload_d = 1'b0;
        unique case (state_q)
            RUN:    if (RetireRedirect && !RetireStall) state_d = DRAIN;
            // count_q is the pre-edge occupancy, so the reload lands one
            // cycle after the last drained update and never overlaps it.
            DRAIN:  if (count_q == '0) begin
                        state_d  = RELOAD;
                        reload_d = 1'b1;
                    end
            RELOAD: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            UpdateInAble <= 1'b0;
            UpdateCall   <= 1'b0;
            UpdateReturn <= 1'b0;
            UpdateInDate <= '0;
            UpdateReload <= 1'b0;
        end else begin
            state_q      <= state_d;
            UpdateReload <= reload_d;
            wr_ptr_q     <= wr_ptr_q + AW'(push0) + AW'(push1);
            rd_ptr_q     <= rd_ptr_q + AW'(pop);
            count_q      <= count_q + CW'(push0) + CW'(push1) - CW'(pop);
            UpdateInAble <= pop;
            UpdateCall   <= pop && head[ADDR_W];
            UpdateReturn <= pop && !head[ADDR_W];
            UpdateInDate <= pop ? head[ADDR_W-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_ras_retire_update.sv
// tb/tb_ras_retire_update.sv - scoreboard bench for ras_retire_update
module tb_ras_retire_update;
    logic        Clk = 1'b0;
    logic        Rest;
    logic        Retire0Able, Retire1Able, RetireRedirect;
    logic [31:0] Retire0Pc, Retire1Pc;
    logic [1:0]  Retire0Type, Retire1Type;
    logic        RetireStall, UpdateInAble, UpdateCall, UpdateReturn, UpdateReload;
    logic [31:0] UpdateInDate;

    typedef struct {
        logic        call;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_able;
    logic seen_stall;
    logic accepted;
    logic got_reload;

    ras_retire_update #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
        .Clk(Clk), .Rest(Rest),
        .Retire0Able(Retire0Able), .Retire0Pc(Retire0Pc), .Retire0Type(Retire0Type),
        .Retire1Able(Retire1Able), .Retire1Pc(Retire1Pc), .Retire1Type(Retire1Type),
        .RetireRedirect(RetireRedirect), .RetireStall(RetireStall),
        .UpdateInAble(UpdateInAble), .UpdateCall(UpdateCall),
        .UpdateReturn(UpdateReturn), .UpdateInDate(UpdateInDate),
        .UpdateReload(UpdateReload)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic able, input logic [31:0] pc, input logic [1:0] t);
        exp_t e;
        if (able && (t == 2'b01 || t == 2'b10)) begin
            e.call = (t == 2'b01);
            e.data = (t == 2'b01) ? pc + 32'd4 : 32'd0;
            sbq.push_back(e);
        end
    endtask

    // Drive one cycle of retire inputs, record what the DUT will accept,
    // then check the outputs produced by that edge against the scoreboard.
    task automatic step(input logic a0, input logic [31:0] pc0, input logic [1:0] t0,
                        input logic a1, input logic [31:0] pc1, input logic [1:0] t1,
                        input logic redir);
        exp_t e;
        Retire0Able = a0; Retire0Pc = pc0; Retire0Type = t0;
        Retire1Able = a1; Retire1Pc = pc1; Retire1Type = t1;
        RetireRedirect = redir;
        #1;
        accepted = !RetireStall;
        if (accepted) begin
            push_exp(a0, pc0, t0);
            push_exp(a1, pc1, t1);
        end
        prev_able = UpdateInAble;
        @(posedge Clk);
        #1;
        if (UpdateInAble) begin
            if (sbq.size() == 0) chk("spurious_update", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("upd_call", UpdateCall, e.call);
                chk("upd_ret", UpdateReturn, !e.call);
                chk("upd_data", UpdateInDate, e.data);
            end
        end else begin
            chk("idle_flags", {UpdateCall, UpdateReturn}, 0);
            chk("idle_data", UpdateInDate, 0);
        end
        chk("reload_excl", UpdateReload & UpdateInAble, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin idle(); n++; end
        chk("drain_timeout", sbq.size(), 0);
        idle();
    endtask

    initial begin
        Rest = 1'b1;
        Retire0Able = 0; Retire0Pc = 0; Retire0Type = 0;
        Retire1Able = 0; Retire1Pc = 0; Retire1Type = 0;
        RetireRedirect = 0;
        #1;
        chk("rst_outs", {UpdateInAble, UpdateCall, UpdateReturn, UpdateReload}, 0);
        chk("rst_data", UpdateInDate, 0);
        chk("rst_stall", RetireStall, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rest = 1'b0;

        // Single call: visible only after the second edge, gone after the third.
        step(1, 32'h1C000100, 2'b01, 0, 0, 0, 0);
        chk("single_lat", UpdateInAble, 0);
        idle();
        chk("single_able", UpdateInAble, 1);
        chk("single_data", UpdateInDate, 32'h1C000104);
        idle();
        chk("single_after", {UpdateInAble, UpdateCall, UpdateReturn, UpdateReload}, 0);

        // Dual retire, then slot 1 alone, then non-call/return types.
        step(1, 32'h200, 2'b01, 1, 32'h204, 2'b10, 0);
        drain_all();
        step(0, 32'h300, 2'b01, 1, 32'h400, 2'b10, 0);
        drain_all();
        step(1, 32'h500, 2'b00, 1, 32'h600, 2'b11, 0);
        chk("none_pushed", sbq.size(), 0);
        drain_all();

        // Backpressure with wrap of the return address.
        seen_stall = 0;
        for (int i = 0; i < 10; i++) begin
            seen_stall |= RetireStall;
            step(1, (i == 0) ? 32'hFFFFFFFC : 32'h1000 + i * 16, 2'b01,
                 1, 32'h8000 + i * 16, 2'b01, 0);
            chk("stall_bp", RetireStall, sbq.size() > 2);
        end
        chk("bp_stall_seen", seen_stall, 1);
        drain_all();

        // Redirect with a backlog of three entries.
        step(1, 32'hA00, 2'b01, 1, 32'hA10, 2'b01, 0);
        step(1, 32'hA20, 2'b01, 1, 32'hA30, 2'b10, 0);
        chk("backlog3", sbq.size(), 3);
        chk("backlog_stall", RetireStall, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 32'hB00, 2'b01, 0, 0, 0, 1);
            if (accepted) break;
        end
        chk("redir_accepted", accepted, 1);
        got_reload = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (UpdateReload) begin
                got_reload = 1;
                chk("reload_after_last", prev_able, 1);
                chk("reload_sb_empty", sbq.size(), 0);
                break;
            end
            chk("stall_in_drain", RetireStall, 1);
        end
        chk("reload_seen", got_reload, 1);
        idle();
        chk("reload_len", UpdateReload, 0);
        chk("stall_release", RetireStall, 0);

        // Redirect on an empty FIFO with a non-call/return slot.
        step(1, 32'hC00, 2'b00, 0, 0, 0, 1);
        chk("empty_e0", {UpdateReload, UpdateInAble, RetireStall}, 3'b001);
        idle();
        chk("empty_e1", {UpdateReload, UpdateInAble, RetireStall}, 3'b101);
        idle();
        chk("empty_e2", {UpdateReload, UpdateInAble, RetireStall}, 3'b000);

        // Async reset in DRAIN with entries pending.
        step(1, 32'hD00, 2'b01, 1, 32'hD10, 2'b10, 1);
        idle();
        chk("pre_rst_able", UpdateInAble, 1);
        #2;
        Rest = 1'b1;
        #1;
        chk("async_outs", {UpdateInAble, UpdateCall, UpdateReturn, UpdateReload}, 0);
        chk("async_data", UpdateInDate, 0);
        chk("async_stall", RetireStall, 0);
        sbq.delete();
        @(negedge Clk);
        Rest = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("post_rst_quiet", {UpdateInAble, UpdateReload, RetireStall}, 0);
        end

        chk("sb_final", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
